mux_serializer: RTL and testbench
=================================

MUX_SERIALIZER -- requirements
Module: mux_serializer

Interface
REQ-001 Parameter MSB_FIRST, default 0: bit order; 0 = sel counts 0 to 7, 1 = sel counts 7 to 0.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 din  input  8  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a word offered for transfer.
REQ-006 din_ready  output  1  block accepts din this cycle.
REQ-007 sel  output  3  index of bit currently presented; drives the 8:1 mux select stage.
REQ-008 dout  output  1  serial bit = held_word[sel].
REQ-009 dout_valid  output  1  dout carries a valid bit.
REQ-010 dout_ready  input  1  downstream accepts dout this cycle.
REQ-011 last  output  1  presented bit is final bit of the word.
REQ-012 busy  output  1  a word is held and serialization is in progress.
REQ-013 words_sent  output  8  count of completed words, modulo 256.

Function
REQ-014 Word transfer SHALL occur on any rising edge with din_valid=1 and din_ready=1; bit transfer SHALL occur on any rising edge with dout_valid=1 and dout_ready=1.
REQ-015 FSM states SHALL be IDLE and SEND only.
REQ-016 IDLE: din_ready=1, dout_valid=0, busy=0, dout=0, last=0; sel held at start index (0 if MSB_FIRST=0, 7 if MSB_FIRST=1).
REQ-017 IDLE + word transfer: latch din into held_word, sel=start index, go to SEND; first bit valid on the next cycle (1-cycle latency).
REQ-018 SEND: dout_valid=1, busy=1, dout=held_word[sel] combinationally from registered state.
REQ-019 SEND, bit transfer, sel not end index: sel steps by one toward end index (end index = 7 if MSB_FIRST=0, 0 if MSB_FIRST=1).
REQ-020 last SHALL be 1 exactly when in SEND with sel = end index.
REQ-021 SEND, dout_ready=0: sel, held_word, dout and last SHALL hold unchanged; no bit is skipped or repeated.
REQ-022 din_ready SHALL be 1 in IDLE, and in SEND only when last=1 and dout_ready=1 (combinational path dout_ready to din_ready); otherwise 0.
REQ-023 SEND, final bit transfer with simultaneous word transfer: latch new din, sel=start index, remain in SEND; zero bubble between words.
REQ-024 SEND, final bit transfer without word transfer: go to IDLE.
REQ-025 words_sent SHALL increment by 1 on every final bit transfer, wrapping 255 to 0.
REQ-026 din SHALL be ignored when no word transfer occurs; held_word SHALL change only on word transfer.
REQ-027 A word of 8 bits SHALL take exactly 8 bit transfers; with dout_ready held 1, back-to-back words SHALL stream at 1 bit per cycle.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, held_word=0, sel=start index, words_sent=0, dout=0, dout_valid=0, last=0, busy=0, din_ready=0 while rst_n=0.
REQ-029 Reset asserted mid-word SHALL discard the partial word without incrementing words_sent; after rst_n release the first edge SHALL be in IDLE with din_ready=1.

Verification
REQ-030 MSB_FIRST=0, din=8'hA5 accepted, dout_ready=1 -> dout sequence 1,0,1,0,0,1,0,1 on sel 0..7, last only at sel=7, words_sent 0->1, then IDLE.
REQ-031 MSB_FIRST=1, din=8'hA5 -> dout sequence 1,0,1,0,0,1,0,1 on sel 7..0, last only at sel=0.
REQ-032 din 8'h0F then 8'hF0 offered continuously, dout_ready=1 -> 16 consecutive valid cycles, no gap, din_ready pulses only with sel=7 bit.
REQ-033 din=8'h3C, dout_ready toggled 1,0,0,1,... -> dout/sel frozen during 0 cycles, bit stream still 0,0,1,1,1,1,0,0.
REQ-034 rst_n pulsed low at sel=4 of word 8'hFF -> outputs cleared asynchronously, words_sent=0, next word 8'h01 serialized from sel=0.
REQ-035 256 words streamed -> words_sent wraps 255 to 0 on final bit of word 256.

Source files
------------

// File: rtl/mux_serializer.sv
// Byte-to-bit serializer: latches a parallel word and walks an 8:1 mux select
// across it under a valid/ready handshake on both sides.
module mux_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [2:0] sel,
    output logic       dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       last,
    output logic       busy,
    output logic [7:0] words_sent
);

    localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] END_IDX   = MSB_FIRST ? 3'd0 : 3'd7;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e     state_q;
    logic [7:0] held_q;
    logic [2:0] sel_q;
    logic [2:0] sel_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       in_send;
    logic       at_end;
    logic       bit_xfer;
    logic       word_xfer;

    assign in_send   = (state_q == SEND);
    assign at_end    = (sel_q == END_IDX);
    assign bit_xfer  = in_send && dout_ready;
    assign word_xfer = din_valid && din_ready;

    assign sel_d = MSB_FIRST ? sel_q - 3'd1 : sel_q + 3'd1;
    assign cnt_d = cnt_q + 8'd1;

    // din_ready is held low while reset is asserted, even though state is IDLE
    assign din_ready  = rst_n && (!in_send || (at_end && dout_ready));
    assign dout_valid = in_send;
    assign busy       = in_send;
    assign last       = in_send && at_end;
    assign dout       = in_send && held_q[sel_q];
    assign sel        = sel_q;
    assign words_sent = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            held_q  <= 8'h00;
            sel_q   <= START_IDX;
            cnt_q   <= 8'h00;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sel_q <= START_IDX;
                    if (word_xfer) begin
                        held_q  <= din;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bit_xfer) begin
                        if (at_end) begin
                            cnt_q <= cnt_d;
                            sel_q <= START_IDX;
                            if (word_xfer) begin
                                held_q <= din;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            sel_q <= sel_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: LSB-first and MSB-first instances share
// the input stimulus and are checked against hand-computed bit streams.
module tb_mux_serializer;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       dout_ready;

    logic       l_din_ready, l_dout, l_dout_valid, l_last, l_busy;
    logic [2:0] l_sel;
    logic [7:0] l_words;
    logic       m_din_ready, m_dout, m_dout_valid, m_last, m_busy;
    logic [2:0] m_sel;
    logic [7:0] m_words;

    int n_chk;
    int n_pass;

    mux_serializer #(.MSB_FIRST(1'b0)) u_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (l_din_ready),
        .sel        (l_sel),
        .dout       (l_dout),
        .dout_valid (l_dout_valid),
        .dout_ready (dout_ready),
        .last       (l_last),
        .busy       (l_busy),
        .words_sent (l_words)
    );

    mux_serializer #(.MSB_FIRST(1'b1)) u_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (m_din_ready),
        .sel        (m_sel),
        .dout       (m_dout),
        .dout_valid (m_dout_valid),
        .dout_ready (dout_ready),
        .last       (m_last),
        .busy       (m_busy),
        .words_sent (m_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] w2;
        logic [7:0] seq;
        logic [3:0] pat;
        int k;
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        din = 8'h00;
        din_valid = 1'b0;
        dout_ready = 1'b1;

        // reset state
        #12;
        chk("rst_din_ready", l_din_ready, 0);
        chk("rst_dout_valid", l_dout_valid, 0);
        chk("rst_busy", l_busy, 0);
        chk("rst_last", l_last, 0);
        chk("rst_dout", l_dout, 0);
        chk("rst_sel_lsb", l_sel, 0);
        chk("rst_sel_msb", m_sel, 7);
        chk("rst_words", l_words, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("idle_din_ready", l_din_ready, 1);

        // A5 on both bit orders; expected stream 1,0,1,0,0,1,0,1
        seq = 8'b1010_0101;
        din = 8'hA5;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        din = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            chk("a5_valid", l_dout_valid, 1);
            chk("a5_sel_lsb", l_sel, i);
            chk("a5_dout_lsb", l_dout, seq[i]);
            chk("a5_last_lsb", l_last, (i == 7));
            chk("a5_sel_msb", m_sel, 7 - i);
            chk("a5_dout_msb", m_dout, seq[i]);
            chk("a5_last_msb", m_last, (i == 7));
            step();
        end
        chk("a5_words", l_words, 1);
        chk("a5_idle_valid", l_dout_valid, 0);
        chk("a5_idle_busy", l_busy, 0);
        chk("a5_idle_ready", l_din_ready, 1);

        // 0F then F0 back to back
        w = 8'h0F;
        w2 = 8'hF0;
        din = w;
        din_valid = 1'b1;
        step();
        din = w2;
        for (int i = 0; i < 16; i++) begin
            chk("bb_valid", l_dout_valid, 1);
            chk("bb_din_ready", l_din_ready, (i % 8 == 7));
            chk("bb_dout", l_dout, (i < 8) ? w[i] : w2[i - 8]);
            step();
            if (i == 7) begin
                din_valid = 1'b0;
                din = 8'h00;
            end
        end
        chk("bb_words", l_words, 3);
        chk("bb_idle", l_dout_valid, 0);

        // 3C with stalls: stream must be 0,0,1,1,1,1,0,0
        w = 8'h3C;
        pat = 4'b1001;
        din = w;
        din_valid = 1'b1;
        dout_ready = 1'b0;
        step();
        din_valid = 1'b0;
        din = 8'hFF;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            dout_ready = pat[c % 4];
            #1;
            chk("st_sel", l_sel, k);
            chk("st_dout", l_dout, w[k]);
            chk("st_din_ready", l_din_ready, (k == 7) && dout_ready);
            step();
            if (pat[c % 4]) k++;
        end
        chk("st_done", (k == 8), 1);
        chk("st_words", l_words, 4);
        dout_ready = 1'b1;

        // asynchronous reset mid-word
        din = 8'hFF;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mr_sel4", l_sel, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", l_dout_valid, 0);
        chk("mr_sel", l_sel, 0);
        chk("mr_words", l_words, 0);
        chk("mr_din_ready", l_din_ready, 0);
        chk("mr_busy", l_busy, 0);
        chk("mr_dout", l_dout, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mr_rel_ready", l_din_ready, 1);
        w = 8'h01;
        din = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("mr_n_sel", l_sel, i);
            chk("mr_n_dout", l_dout, w[i]);
            step();
        end
        chk("mr_n_words", l_words, 1);

        // 256-word wrap of words_sent
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        din = 8'h96;
        din_valid = 1'b1;
        step();
        for (int i = 0; i < 255 * 8; i++) step();
        chk("wr_255", l_words, 255);
        chk("wr_sel0", l_sel, 0);
        chk("wr_busy", l_busy, 1);
        for (int i = 0; i < 7; i++) step();
        chk("wr_last", l_last, 1);
        chk("wr_hold", l_words, 255);
        din_valid = 1'b0;
        step();
        chk("wr_wrap", l_words, 0);
        chk("wr_msb_wrap", m_words, 0);
        chk("wr_idle", l_dout_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
